// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART transmit control path.
package uart_ctrl_pkg;

  localparam int unsigned UART_BYTE_W        = 8;
  localparam int unsigned UART_START_TIMEOUT = 16;
  localparam int unsigned SENT_CNT_W         = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Cyclic priority search: first valid index at or after rr_ptr.
module uart_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  // rr_ptr + k, wrapped modulo NUM_REQ (rr_ptr is always below NUM_REQ)
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan NUM_REQ positions starting at rr_ptr, keep the first hit
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[wrap_add(rr_ptr, k)]) begin
        found = 1'b1;
        index = wrap_add(rr_ptr, k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART Tx engine between NUM_REQ byte
// producers, with packet lock until a byte flagged req_last is delivered.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned BYTE_W        = UART_BYTE_W,
  parameter int unsigned START_TIMEOUT = UART_START_TIMEOUT,
  localparam int unsigned IDX_W = $clog2(NUM_REQ),
  localparam int unsigned TO_W  = $clog2(START_TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_byte,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      active,
  output logic                      err_timeout,
  output logic [SENT_CNT_W-1:0]     sent_count
);

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic             lock_r;
  logic             last_r;
  logic [TO_W-1:0]  to_cnt;
  logic             pick_found;
  logic [IDX_W-1:0] pick_index;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .found     (pick_found),
    .index     (pick_index)
  );

  // Arbitration / launch FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock_r      <= 1'b0;
      last_r      <= 1'b0;
      to_cnt      <= '0;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
      sent_count  <= '0;
    end else begin
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          // Engine may still be finishing a frame launched before a reset
          if (!tx_busy && pick_found) begin
            grant_id  <= pick_index;
            req_ready <= onehot(pick_index);
            active    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (req_valid[grant_id] && req_ready[grant_id]) begin
            tx_byte   <= req_data[32'(grant_id) * BYTE_W +: BYTE_W];
            last_r    <= req_last[grant_id];
            req_ready <= '0;
            tx_start  <= 1'b1;
            state     <= LAUNCH;
          end else if (!req_valid[grant_id]) begin
            // Producer withdrew; an abandoned packet still passes the turn on
            if (lock_r) rr_ptr <= next_idx(grant_id);
            lock_r    <= 1'b0;
            req_ready <= '0;
            active    <= 1'b0;
            state     <= IDLE;
          end
        end
        LAUNCH: begin
          to_cnt <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_done) begin
            state <= DONE;
          end else if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TO_W'(START_TIMEOUT - 1)) begin
            to_cnt      <= TO_W'(START_TIMEOUT);
            err_timeout <= 1'b1;
            lock_r      <= 1'b0;
            rr_ptr      <= next_idx(grant_id);
            active      <= 1'b0;
            state       <= IDLE;
          end else if (to_cnt != TO_W'(START_TIMEOUT)) begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        WAIT_DONE: begin
          if (tx_done) state <= DONE;
        end
        DONE: begin
          sent_count <= sent_count + SENT_CNT_W'(1);
          if (!last_r) begin
            lock_r    <= 1'b1;
            req_ready <= onehot(grant_id);
            state     <= LOAD;
          end else begin
            lock_r <= 1'b0;
            rr_ptr <= next_idx(grant_id);
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
